// File: rtl/iq_merge.sv
// iq_merge: receive-side I/Q merger.
// Majority-votes the demodulated bipolar I and Q streams over one symbol window and
// re-serialises the decided bits, Q first then I, while the next symbol accumulates.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   I, Q       2-bit bipolar symbols: 01 = +1, 11 = -1, 00/10 = no vote
//   sym_sync   one-cycle pulse marking clock 0 of a symbol
//   ser_o      recovered serial bit
//   ser_valid  high while ser_o carries decided data
//   sync_err   one-cycle pulse when sym_sync arrives off the expected symbol start
module iq_merge #(
  parameter int unsigned IQ_DIV_MAX = 100,  // clocks per sample strobe
  parameter int unsigned BIT_SAMPLE = 100,  // sample strobes per serial bit
  parameter int unsigned CNT_W      = 9     // vote-counter width, holds 2*BIT_SAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] I,
  input  logic [1:0] Q,
  input  logic       sym_sync,
  output logic       ser_o,
  output logic       ser_valid,
  output logic       sync_err
);

  localparam int unsigned SymClk = 2 * BIT_SAMPLE * IQ_DIV_MAX;
  localparam int unsigned KW     = (SymClk > 1) ? $clog2(SymClk) : 1;
  localparam int unsigned DW     = (IQ_DIV_MAX > 1) ? $clog2(IQ_DIV_MAX) : 1;

  localparam logic [KW-1:0] KLast   = KW'(SymClk - 1);
  localparam logic [KW-1:0] KHalf   = KW'(SymClk / 2);
  localparam logic [DW-1:0] DLast   = DW'(IQ_DIV_MAX - 1);
  localparam logic [DW-1:0] DStrobe = DW'(IQ_DIV_MAX / 2);

  typedef enum logic [1:0] {StIdle, StAcq, StRun} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] i_pos_q, i_pos_d, i_neg_q, i_neg_d;
  logic [CNT_W-1:0] q_pos_q, q_pos_d, q_neg_q, q_neg_d;
  logic             i_dec_q, i_dec_d, q_dec_q, q_dec_d;
  logic             ser_o_q, ser_o_d;
  logic             ser_valid_q, ser_valid_d;
  logic             sync_err_q, sync_err_d;

  logic             restart, active, strobe, boundary;
  logic [KW-1:0]    cur_k;
  logic [DW-1:0]    cur_div;
  logic [CNT_W-1:0] i_pos_c, i_neg_c, q_pos_c, q_neg_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A sync on the expected k=0 is redundant; any other sync (or the first one out of
  // idle) makes the current cycle clock 0 of a fresh symbol.
  assign restart  = sym_sync && ((state_q == StIdle) || (k_q != '0));
  assign active   = restart || (state_q != StIdle);
  assign cur_k    = restart ? '0 : k_q;
  assign cur_div  = restart ? '0 : div_q;
  assign strobe   = active && (cur_div == DStrobe);
  assign boundary = active && (cur_k == KLast);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    div_d       = div_q;
    i_pos_d     = i_pos_q;
    i_neg_d     = i_neg_q;
    q_pos_d     = q_pos_q;
    q_neg_d     = q_neg_q;
    i_dec_d     = i_dec_q;
    q_dec_d     = q_dec_q;
    ser_o_d     = ser_o_q;
    ser_valid_d = ser_valid_q;
    sync_err_d  = 1'b0;

    // Vote tallies including this cycle's strobe, so a strobe on the boundary counts.
    i_pos_c = restart ? '0 : i_pos_q;
    i_neg_c = restart ? '0 : i_neg_q;
    q_pos_c = restart ? '0 : q_pos_q;
    q_neg_c = restart ? '0 : q_neg_q;
    if (strobe) begin
      if (I == 2'b01)      i_pos_c = sat_inc(i_pos_c);
      else if (I == 2'b11) i_neg_c = sat_inc(i_neg_c);
      if (Q == 2'b01)      q_pos_c = sat_inc(q_pos_c);
      else if (Q == 2'b11) q_neg_c = sat_inc(q_neg_c);
    end

    if (active) begin
      k_d     = boundary ? '0 : cur_k + KW'(1);
      div_d   = (cur_div == DLast) ? '0 : cur_div + DW'(1);
      i_pos_d = i_pos_c;
      i_neg_d = i_neg_c;
      q_pos_d = q_pos_c;
      q_neg_d = q_neg_c;

      if (restart) begin
        state_d     = StAcq;
        sync_err_d  = (state_q != StIdle);
        ser_valid_d = 1'b0;  // ser_o deliberately holds its last value
      end else if (state_q == StRun) begin
        if (cur_k == '0) begin
          ser_o_d     = q_dec_q;
          ser_valid_d = 1'b1;
        end else if (cur_k == KHalf) begin
          ser_o_d = i_dec_q;
        end
      end

      if (boundary) begin
        i_dec_d = (i_pos_c > i_neg_c);
        q_dec_d = (q_pos_c > q_neg_c);
        i_pos_d = '0;
        i_neg_d = '0;
        q_pos_d = '0;
        q_neg_d = '0;
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      div_q       <= '0;
      i_pos_q     <= '0;
      i_neg_q     <= '0;
      q_pos_q     <= '0;
      q_neg_q     <= '0;
      i_dec_q     <= 1'b0;
      q_dec_q     <= 1'b0;
      ser_o_q     <= 1'b0;
      ser_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      div_q       <= div_d;
      i_pos_q     <= i_pos_d;
      i_neg_q     <= i_neg_d;
      q_pos_q     <= q_pos_d;
      q_neg_q     <= q_neg_d;
      i_dec_q     <= i_dec_d;
      q_dec_q     <= q_dec_d;
      ser_o_q     <= ser_o_d;
      ser_valid_q <= ser_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign ser_o     = ser_o_q;
  assign ser_valid = ser_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_iq_merge.sv
// tb_iq_merge: self-checking bench for iq_merge with IQ_DIV_MAX=4, BIT_SAMPLE=4
// (32 clocks and 8 strobes per symbol). Symbol contents come from a table of vote
// patterns with hand-derived decisions; per-cycle output expectations are pushed to
// a scoreboard when stimulus is scheduled and checked on the falling edge.
module tb_iq_merge;

  localparam int unsigned IqDiv     = 4;
  localparam int unsigned BitSample = 4;
  localparam int unsigned CntW      = 9;
  localparam int          SymClk    = 2 * BitSample * IqDiv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_sync = 1'b0;
  logic [1:0] I = 2'b00;
  logic [1:0] Q = 2'b00;
  logic       ser_o, ser_valid, sync_err;

  iq_merge #(
    .IQ_DIV_MAX(IqDiv),
    .BIT_SAMPLE(BitSample),
    .CNT_W     (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .I        (I),
    .Q        (Q),
    .sym_sync (sym_sync),
    .ser_o    (ser_o),
    .ser_valid(ser_valid),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // Inputs driven while cyc==c are sampled by the edge that moves cyc to c+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One symbol's strobe codes, first listed code = strobe 0, plus its decisions.
  typedef struct {
    logic [15:0] ic;
    logic [15:0] qc;
    logic        exp_i;
    logic        exp_q;
  } vec_t;
  vec_t tbl [8];

  typedef struct {
    int    c;
    logic  v;
    logic  o;
    logic  e;
    string nm;
  } exp_t;
  exp_t sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic push(input int c, input logic v, input logic o, input logic e,
                      input string nm);
    exp_t x;
    x.c  = c;
    x.v  = v;
    x.o  = o;
    x.e  = e;
    x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic push_quiet(input int c0, input int c1, input logic v, input logic o,
                            input logic e, input string nm);
    for (int c = c0; c <= c1; c++) push(c, v, o, e, nm);
  endtask

  // Symbol starting at cycle b shows Q on b+33..b+48 and I on b+49..b+64.
  task automatic push_out(input int b, input int idx, input int sym, input int off0,
                          input int off1);
    for (int off = off0; off <= off1; off++) begin
      push(b + off, 1'b1, (off <= 48) ? tbl[idx].exp_q : tbl[idx].exp_i, 1'b0,
           $sformatf("sym%0d_out_off%0d", sym, off));
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c == cyc) begin
        n_checks++;
        if (ser_valid === sb[i].v && sync_err === sb[i].e && ser_o === sb[i].o) begin
          n_pass++;
        end else begin
          $display("FAIL %s cyc=%0d: got valid=%b ser=%b err=%b, want valid=%b ser=%b err=%b",
                   sb[i].nm, cyc, ser_valid, ser_o, sync_err, sb[i].v, sb[i].o, sb[i].e);
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive_cycle(input logic r, input logic s, input logic [1:0] i,
                             input logic [1:0] q);
    rst      = r;
    sym_sync = s;
    I        = i;
    Q        = q;
    @(posedge clk);
    #1;
  endtask

  // Table codes on strobe clocks, random junk everywhere else.
  task automatic drive_sym(input int idx, input bit with_sync, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      logic [1:0] iv, qv;
      if (k % IqDiv == IqDiv / 2) begin
        iv = tbl[idx].ic[15 - 2 * (k / IqDiv) -: 2];
        qv = tbl[idx].qc[15 - 2 * (k / IqDiv) -: 2];
      end else begin
        iv = 2'($urandom_range(0, 3));
        qv = 2'($urandom_range(0, 3));
      end
      drive_cycle(1'b0, with_sync && (k == 0), iv, qv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1);
  end

  initial begin
    int b0, b10, s2, r, b14;

    tbl[0] = '{ic: 16'h5555, qc: 16'hFFFF, exp_i: 1'b1, exp_q: 1'b0};
    tbl[1] = '{ic: 16'hFFFF, qc: 16'h5555, exp_i: 1'b0, exp_q: 1'b1};
    // I 5 vs 3 -> 1; Q 4 vs 4 tie -> 0
    tbl[2] = '{ic: {2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01},
               qc: {2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 2'b11},
               exp_i: 1'b1, exp_q: 1'b0};
    // I empty -> 0; Q 2 vs 1 among 10 codes -> 1
    tbl[3] = '{ic: 16'h0000,
               qc: {2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10},
               exp_i: 1'b0, exp_q: 1'b1};
    // I only 10 codes -> 0; Q single +1 among 10 -> 1
    tbl[4] = '{ic: 16'hAAAA,
               qc: {2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10},
               exp_i: 1'b0, exp_q: 1'b1};
    // I 2 vs 2 -> 0; Q 2 vs 4 -> 0
    tbl[5] = '{ic: {2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00},
               qc: {2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11},
               exp_i: 1'b0, exp_q: 1'b0};
    // I single +1 on first strobe -> 1; Q all +1 -> 1
    tbl[6] = '{ic: {2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
               qc: 16'h5555, exp_i: 1'b1, exp_q: 1'b1};
    // I single -1 -> 0; Q single +1 on last strobe -> 1
    tbl[7] = '{ic: {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
               qc: {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01},
               exp_i: 1'b0, exp_q: 1'b1};

    // Reset with random I/Q, then idle without sym_sync: all outputs stay low.
    push_quiet(1, 11, 1'b0, 1'b0, 1'b0, "reset_idle");
    for (int n = 0; n < 3; n++)
      drive_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    for (int n = 0; n < 8; n++)
      drive_cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Ten symbols with aligned sync each: valid from +33, continuous, no sync_err.
    b0 = cyc;
    push_quiet(b0 + 1, b0 + 32, 1'b0, 1'b0, 1'b0, "acq_wait");
    for (int n = 0; n < 9; n++) push_out(b0 + SymClk * n, n % 8, n, 33, 64);
    push_out(b0 + SymClk * 9, 1, 9, 33, 45);
    for (int n = 0; n < 10; n++) drive_sym(n % 8, 1'b1, SymClk);

    // Misaligned sync at k=13 of a running symbol.
    b10 = cyc;
    s2  = b10 + 13;
    push(s2 + 1, 1'b0, tbl[1].exp_q, 1'b1, "sync_err_pulse");
    push_quiet(s2 + 2, s2 + 32, 1'b0, tbl[1].exp_q, 1'b0, "resync_hold");
    push_out(s2, 0, 11, 33, 64);
    push_out(s2 + SymClk, 1, 12, 33, 52);
    drive_sym(2, 1'b1, 13);
    drive_sym(0, 1'b1, SymClk);
    drive_sym(1, 1'b0, SymClk);
    drive_sym(2, 1'b0, 20);

    // One-cycle reset mid-run, then strong I/Q with no sync must be ignored.
    r = cyc;
    push_quiet(r + 1, r + 46, 1'b0, 1'b0, 1'b0, "post_reset_idle");
    drive_cycle(1'b1, 1'b0, 2'b01, 2'b01);
    for (int n = 0; n < 45; n++) drive_cycle(1'b0, 1'b0, 2'b01, 2'b01);

    // Recovery after re-sync from idle.
    b14 = cyc;
    push_quiet(b14 + 1, b14 + 32, 1'b0, 1'b0, 1'b0, "reacq_wait");
    push_out(b14, 5, 14, 33, 64);
    push_out(b14 + SymClk, 4, 15, 33, 64);
    drive_sym(5, 1'b1, SymClk);
    drive_sym(4, 1'b1, SymClk);
    drive_sym(7, 1'b1, SymClk);
    repeat (2) @(posedge clk);
    #1;

    if (sb.size() != 0) begin
      n_checks += sb.size();
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
